// File: rtl/reg_writeback_pkg.sv
// Shared widths and the write-back entry type for the register-file write stage.
package wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 64;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [REG_ADDR_W-1:0] a);
    onehot_reg    = '0;
    onehot_reg[a] = 1'b1;
  endfunction
endpackage

// File: rtl/reg_writeback_if.sv
// Producer handshakes (ALU, load unit) and the register-file write port.
interface reg_writeback_if;
  import wb_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0]     alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_data;
  logic                  write_en;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0]     write_data;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, write_en, write_addr, write_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, write_en, write_addr, write_data
  );
endinterface

// File: rtl/reg_writeback_fifo.sv
// Synchronous FIFO of pending ALU results; exposes per-slot valid/addr so the
// top level can build the pending-destination mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  wb_entry_t                        push_entry,
  input  logic                             pop,
  output wb_entry_t                        head,
  output logic                             full,
  output logic                             empty,
  output logic [CNT_W-1:0]                 count,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr
);
  wb_entry_t        slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] off;
    assign off          = PTR_W'(i) - rd_ptr;
    assign ent_valid[i] = (CNT_W'(off) < count);
    assign ent_addr[i]  = slots[i].addr;
  end
endmodule

// File: rtl/reg_writeback.sv
// Write-back arbiter: ALU FIFO vs. load unit, starvation override, registered
// write port, pending mask. Optional bypass under REG_WRITEBACK_BYPASS_EN.
module reg_writeback
  import wb_pkg::*;
#(
  parameter  int ALU_FIFO_DEPTH = 4,
  parameter  int STARVE_LIMIT   = 3,
  localparam int CNT_W          = $clog2(ALU_FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  reg_writeback_if.slave             bus,
  input  logic [2:0][REG_ADDR_W-1:0] rd_addr,
  output logic [NUM_REGS-1:0]        pend_mask,
  output logic [CNT_W-1:0]           fifo_count,
  output logic [2:0]                 byp_hit,
  output logic [DATA_W-1:0]          byp_data
);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t                                head;
  logic                                     fifo_full;
  logic                                     fifo_empty;
  logic [ALU_FIFO_DEPTH-1:0]                ent_valid;
  logic [ALU_FIFO_DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;
  logic [SC_W-1:0]                          starve_cnt;
  logic                                     starve_hit;
  logic                                     starve_force;
  logic                                     grant_alu;
  logic                                     grant_mem;
  logic                                     wr_en_q;
  logic [REG_ADDR_W-1:0]                    wr_addr_q;
  logic [DATA_W-1:0]                        wr_data_q;

  wb_fifo #(.DEPTH(ALU_FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (bus.alu_valid & bus.alu_ready),
    .push_entry ('{addr: bus.alu_addr, data: bus.alu_data}),
    .pop        (grant_alu),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr)
  );

  assign starve_hit    = (starve_cnt == SC_W'(STARVE_LIMIT));
  assign starve_force  = starve_hit & ~fifo_empty;
  assign bus.alu_ready = ~fifo_full & ~rst;
  assign bus.mem_ready = ~rst & ~starve_force;
  assign grant_mem     = bus.mem_valid & bus.mem_ready;
  assign grant_alu     = ~fifo_empty & ~rst & (starve_force | ~bus.mem_valid);

  always_ff @(posedge clk) begin
    if (rst || fifo_empty || grant_alu) starve_cnt <= '0;
    else if (grant_mem && !starve_hit)  starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (grant_alu) begin
      wr_en_q   <= 1'b1;
      wr_addr_q <= head.addr;
      wr_data_q <= head.data;
    end else if (grant_mem) begin
      wr_en_q   <= 1'b1;
      wr_addr_q <= bus.mem_addr;
      wr_data_q <= bus.mem_data;
    end else begin
      wr_en_q   <= 1'b0;
    end
  end

  assign bus.write_en   = wr_en_q;
  assign bus.write_addr = wr_addr_q;
  assign bus.write_data = wr_data_q;

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < ALU_FIFO_DEPTH; i++)
      if (ent_valid[i]) pend_mask = pend_mask | onehot_reg(ent_addr[i]);
    if (wr_en_q) pend_mask = pend_mask | onehot_reg(wr_addr_q);
  end

`ifdef REG_WRITEBACK_BYPASS_EN
  // Covers the cycle where the register file still returns the old value.
  always_comb begin
    byp_hit = '0;
    for (int i = 0; i < 3; i++)
      byp_hit[i] = wr_en_q & (wr_addr_q == rd_addr[i]);
  end
  assign byp_data = wr_data_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign byp_hit        = '0;
  assign byp_data       = '0;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a write-order scoreboard on the register-file port.
module tb_reg_writeback;
  import wb_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [2:0][REG_ADDR_W-1:0] rd_addr;
  logic [NUM_REGS-1:0]        pend_mask;
  logic [2:0]                 fifo_count;
  logic [2:0]                 byp_hit;
  logic [DATA_W-1:0]          byp_data;

  reg_writeback_if bus ();

  reg_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rd_addr    (rd_addr),
    .pend_mask  (pend_mask),
    .fifo_count (fifo_count),
    .byp_hit    (byp_hit),
    .byp_data   (byp_data)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_pass   = 0;
  wb_entry_t expq[$];
  wb_entry_t mon_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] a, input logic [63:0] d);
    bus.alu_valid = v;
    bus.alu_addr  = a;
    bus.alu_data  = d;
  endtask

  task automatic drive_mem(input logic v, input logic [4:0] a, input logic [63:0] d);
    bus.mem_valid = v;
    bus.mem_addr  = a;
    bus.mem_data  = d;
  endtask

  // Every register-file write must match the next expected write in grant order.
  always @(negedge clk) begin
    if (bus.write_en === 1'b1) begin
      n_checks++;
      assert (expq.size() > 0) n_pass++;
      else $display("FAIL sb_unexpected_write: observed addr %0d data %h, expected no write",
                    bus.write_addr, bus.write_data);
      if (expq.size() > 0) begin
        mon_exp = expq.pop_front();
        chk("sb_addr", 64'(bus.write_addr), 64'(mon_exp.addr));
        chk("sb_data", bus.write_data, mon_exp.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    rd_addr = '0;
    drive_alu(1'b0, 5'd0, 64'd0);
    drive_mem(1'b0, 5'd0, 64'd0);
    tick();
    tick();
    samp();
    chk("rst_alu_ready",  bus.alu_ready,  0);
    chk("rst_mem_ready",  bus.mem_ready,  0);
    chk("rst_write_en",   bus.write_en,   0);
    chk("rst_write_addr", bus.write_addr, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_fifo_count", fifo_count,     0);
    chk("rst_pend_mask",  pend_mask,      0);
    rst = 1'b0;
    tick();
    samp();
    chk("run_alu_ready", bus.alu_ready, 1);
    chk("run_mem_ready", bus.mem_ready, 1);

    // single ALU write r5 = 0x1234: write_en two cycles after the push
    tick();
    drive_alu(1'b1, 5'd5, 64'h1234);
    expq.push_back('{addr: 5'd5, data: 64'h1234});
    samp();
    chk("alu1_pend_c0", pend_mask, 0);
    tick();
    drive_alu(1'b0, 5'd0, 64'd0);
    samp();
    chk("alu1_wen_c1",   bus.write_en, 0);
    chk("alu1_pend_c1",  pend_mask,    32'h0000_0020);
    chk("alu1_count_c1", fifo_count,   1);
    tick();
    samp();
    chk("alu1_wen_c2",  bus.write_en,   1);
    chk("alu1_addr_c2", bus.write_addr, 5);
    chk("alu1_pend_c2", pend_mask,      32'h0000_0020);
    tick();
    samp();
    chk("alu1_wen_c3",  bus.write_en, 0);
    chk("alu1_pend_c3", pend_mask,    0);

    // memory write: handshake edge, write_en the next cycle
    tick();
    drive_mem(1'b1, 5'd9, 64'hABCD);
    expq.push_back('{addr: 5'd9, data: 64'hABCD});
    samp();
    chk("mem1_ready", bus.mem_ready, 1);
    tick();
    drive_mem(1'b0, 5'd0, 64'd0);
    samp();
    chk("mem1_wen",  bus.write_en, 1);
    chk("mem1_pend", pend_mask,    32'h0000_0200);

    // back-to-back ALU pushes: push and pop together keep the count, r0 is writable
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_alu(1'b1, 5'(i), 64'h3000 + 64'(i));
      expq.push_back('{addr: 5'(i), data: 64'h3000 + 64'(i)});
      samp();
      if (i > 0) chk("b2b_count", fifo_count, 1);
      tick();
    end
    drive_alu(1'b0, 5'd0, 64'd0);
    samp();
    chk("b2b_count_c3", fifo_count,   1);
    chk("b2b_wen_c3",   bus.write_en, 1);
    tick();
    samp();
    chk("b2b_count_c4", fifo_count,   0);
    chk("b2b_wen_c4",   bus.write_en, 1);
    tick();
    samp();
    chk("b2b_wen_c5", bus.write_en, 0);

    // continuous mem traffic fills the FIFO; starvation override after 3 losses
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_mem(1'b1, 5'(10 + i), 64'h1000 + 64'(i));
      drive_alu(1'b1, 5'(20 + i), 64'h2000 + 64'(i));
      expq.push_back('{addr: 5'(10 + i), data: 64'h1000 + 64'(i)});
      samp();
      chk("fill_mem_ready", bus.mem_ready, 1);
      chk("fill_count",     fifo_count,    i);
      tick();
    end
    drive_mem(1'b1, 5'd14, 64'h1004);
    drive_alu(1'b1, 5'd24, 64'h2004);
    expq.push_back('{addr: 5'd20, data: 64'h2000});
    samp();
    chk("full_count",     fifo_count,    4);
    chk("full_alu_ready", bus.alu_ready, 0);
    chk("starve_mem_rdy", bus.mem_ready, 0);
    chk("full_pend",      pend_mask,     32'h00F0_2000);
    tick();
    expq.push_back('{addr: 5'd14, data: 64'h1004});
    samp();
    chk("free_alu_ready", bus.alu_ready,  1);
    chk("free_mem_ready", bus.mem_ready,  1);
    chk("starve_win",     bus.write_addr, 20);
    chk("free_count",     fifo_count,     3);
    tick();
    drive_mem(1'b0, 5'd0, 64'd0);
    drive_alu(1'b0, 5'd0, 64'd0);
    for (int i = 1; i < 5; i++)
      expq.push_back('{addr: 5'(20 + i), data: 64'h2000 + 64'(i)});
    samp();
    chk("drain_count_start", fifo_count, 4);
    repeat (4) tick();
    samp();
    chk("drain_count_end", fifo_count, 0);
    chk("drain_pend_last", pend_mask,  32'h0100_0000);
    tick();
    samp();
    chk("drain_pend_clear", pend_mask,     0);
    chk("drain_mem_ready",  bus.mem_ready, 1);

    // mid-operation reset with 3 FIFO entries and a write in flight
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_mem(1'b1, 5'(16 + i), 64'h4000 + 64'(i));
      drive_alu(1'b1, 5'(26 + i), 64'h5000 + 64'(i));
      expq.push_back('{addr: 5'(16 + i), data: 64'h4000 + 64'(i)});
      tick();
    end
    drive_mem(1'b0, 5'd0, 64'd0);
    drive_alu(1'b0, 5'd0, 64'd0);
    rst = 1'b1;
    samp();
    chk("prerst_count",     fifo_count,    3);
    chk("prerst_wen",       bus.write_en,  1);
    chk("midrst_alu_ready", bus.alu_ready, 0);
    tick();
    rst = 1'b0;
    samp();
    chk("postrst_wen",   bus.write_en, 0);
    chk("postrst_count", fifo_count,   0);
    chk("postrst_pend",  pend_mask,    0);
    repeat (3) tick();
    samp();
    chk("postrst_idle_wen", bus.write_en, 0);

    // bypass on a mem write r7 = 0xDEAD with rd_addr = {7, 3, 7}
    tick();
    rd_addr = {5'd7, 5'd3, 5'd7};
    drive_mem(1'b1, 5'd7, 64'hDEAD);
    expq.push_back('{addr: 5'd7, data: 64'hDEAD});
    samp();
    chk("byp_idle_hit", byp_hit, 0);
    tick();
    drive_mem(1'b0, 5'd0, 64'd0);
    samp();
    chk("byp_wen", bus.write_en, 1);
`ifdef REG_WRITEBACK_BYPASS_EN
    chk("byp_hit",  byp_hit,  3'b101);
    chk("byp_data", byp_data, 64'hDEAD);
`else
    chk("byp_hit_off",  byp_hit,  0);
    chk("byp_data_off", byp_data, 0);
`endif

    tick();
    tick();
    samp();
    chk("sb_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
